mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL use parameter MULT_CYCLES, default 5, busy cycles per mult/multu.
REQ-002 SHALL use parameter DIV_CYCLES, default 10, busy cycles per div/divu.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port Start  in  1  E-stage instruction issues an MD operation this cycle.
REQ-006 SHALL have port MDop  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 treated as none.
REQ-007 SHALL have port A  in  32  rs operand (forwarded).
REQ-008 SHALL have port B  in  32  rt operand (forwarded).
REQ-009 SHALL have port DUseMD  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
REQ-010 SHALL have port HI  out  32  architectural HI register.
REQ-011 SHALL have port LO  out  32  architectural LO register.
REQ-012 SHALL have port Busy  out  1  registered; high while a mult/div is in flight.
REQ-013 SHALL have port StallMD  out  1  combinational; DUseMD & (Busy | (Start & MDop in 1..4)).

Function
REQ-014 SHALL implement states IDLE and RUN with a down-counter cnt (width ceil(log2(DIV_CYCLES+1))).
REQ-015 SHALL, in IDLE with Start and MDop 1..4, latch computed {hi,lo} into pending regs, load cnt with MULT_CYCLES or DIV_CYCLES, and enter RUN.
REQ-016 SHALL hold Busy=1 for exactly N cycles (t+1..t+N for Start at cycle t), N = the loaded count.
REQ-017 SHALL decrement cnt each RUN cycle; on the edge where cnt goes 1->0, write pending to HI/LO and return to IDLE (new values visible at t+N+1).
REQ-018 SHALL compute mult/multu as 64-bit signed/unsigned product: HI = [63:32], LO = [31:0].
REQ-019 SHALL compute div/divu as LO = quotient, HI = remainder; signed division truncates toward zero, remainder takes the dividend's sign.
REQ-020 SHALL, on divide by zero, still run DIV_CYCLES busy cycles and leave HI/LO unchanged at completion.
REQ-021 SHALL, for signed 0x80000000 / 0xFFFFFFFF, produce LO=0x80000000, HI=0.
REQ-022 SHALL, on Start with mthi (mtlo) in IDLE, write A to HI (LO) on the next edge; Busy stays 0.
REQ-023 SHALL ignore Start while in RUN, including mthi/mtlo; pending result and cnt are unaffected.
REQ-024 SHALL keep HI/LO stable during RUN; old values remain readable until completion.
REQ-025 SHALL treat Start with MDop 0 or 7 as no operation.
REQ-026 SHALL keep StallMD purely combinational with no registered path from DUseMD.

Reset
REQ-027 SHALL, while reset=1 at an edge, clear HI, LO, pending regs, and cnt to 0, force IDLE, and drive Busy=0; any in-flight operation is discarded.
REQ-028 SHALL give reset priority over Start on the same edge.

Structure
REQ-029 SHALL place MDop encodings, MULT_CYCLES/DIV_CYCLES defaults, and the state encoding in shared package mdu_pkg.
REQ-030 SHALL isolate the combinational mult/div arithmetic in sub-module mdu_calc (inputs MDop, A, B; outputs hi, lo, dz); the FSM, counter, and HI/LO registers stay in mdu_ctrl.

Verification
REQ-031 SHALL test mult: A=0xFFFFFFFF, B=2, Start at t -> Busy t+1..t+5; HI=0xFFFFFFFF, LO=0xFFFFFFFE at t+6.
REQ-032 SHALL test divu: A=100, B=7 -> Busy 10 cycles; LO=14, HI=2. Signed div A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-033 SHALL test div by zero with HI=0x11, LO=0x22 preset via mthi/mtlo -> Busy 10 cycles; HI=0x11, LO=0x22 afterwards.
REQ-034 SHALL test hazards: DUseMD=1 with Start multu -> StallMD=1 at t and t+1..t+5, 0 at t+6. mthi A=0xABCD with DUseMD=1 -> StallMD=0 and HI=0xABCD next cycle.
REQ-035 SHALL test reset mid-operation: reset at t+3 of a div -> Busy=0, HI=LO=0 at t+4; no later write-back.
REQ-036 SHALL test Start mult while in RUN of a prior div -> ignored; only the div result lands, at its original completion cycle.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg -- shared definitions for the multiply/divide unit.
//   MDop encodings, default busy-cycle counts, FSM state encoding,
//   and small opcode classification helpers used by mdu_ctrl and mdu_calc.
package mdu_pkg;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } mdop_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // True for the four opcodes that occupy the unit for several cycles.
  function automatic logic isMulDiv(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic isDiv(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// mdu_calc -- purely combinational multiply/divide arithmetic.
//   MDop  in  3   operation select (mdu_pkg encodings)
//   A     in  32  rs operand
//   B     in  32  rt operand
//   hi    out 32  upper product word, or remainder for divides
//   lo    out 32  lower product word, or quotient for divides
//   dz    out 1   divide opcode with a zero divisor; result must be discarded
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [2:0]  MDop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        dz
);

  logic signed [63:0] w_sProd;
  logic [63:0]        w_uProd;
  logic               w_bZero;
  logic               w_negA;
  logic               w_negB;
  logic [31:0]        w_magA;
  logic [31:0]        w_divisor;
  logic [31:0]        w_uQuot;
  logic [31:0]        w_uRem;
  logic [31:0]        w_quot;
  logic [31:0]        w_rem;

  assign w_sProd = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign w_uProd = {32'd0, A} * {32'd0, B};
  assign w_bZero = (B == 32'd0);

  // Signed division is done on magnitudes and the signs are restored
  // afterwards: quotient negative when operand signs differ (truncation
  // toward zero), remainder follows the dividend. The magnitude of
  // 0x80000000 wraps to itself, which yields the required 0x80000000 / -1
  // result without a special case. A zero divisor is replaced by 1 so the
  // divider never sees an undefined operation; dz discards that result.
  always_comb begin
    w_negA    = (MDop == MD_DIV) && A[31];
    w_negB    = (MDop == MD_DIV) && B[31];
    w_magA    = w_negA ? -A : A;
    w_divisor = w_bZero ? 32'd1 : (w_negB ? -B : B);
    w_uQuot   = w_magA / w_divisor;
    w_uRem    = w_magA % w_divisor;
    w_quot    = (w_negA ^ w_negB) ? -w_uQuot : w_uQuot;
    w_rem     = w_negA ? -w_uRem : w_uRem;
  end

  // Select the result pair for the requested operation.
  always_comb begin
    hi = 32'd0;
    lo = 32'd0;
    dz = 1'b0;
    case (MDop)
      MD_MULT: begin
        hi = w_sProd[63:32];
        lo = w_sProd[31:0];
      end
      MD_MULTU: begin
        hi = w_uProd[63:32];
        lo = w_uProd[31:0];
      end
      MD_DIV, MD_DIVU: begin
        hi = w_rem;
        lo = w_quot;
        dz = w_bZero;
      end
      default: begin
        hi = 32'd0;
        lo = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl -- multi-cycle multiply/divide control with HI/LO registers.
//   clk      in  1   rising-edge clock
//   reset    in  1   synchronous active-high reset
//   Start    in  1   E-stage issues an MD operation this cycle
//   MDop     in  3   operation (mdu_pkg encodings; 0 and 7 are no-ops)
//   A, B     in  32  forwarded rs / rt operands
//   DUseMD   in  1   D-stage instruction touches the MD unit
//   HI, LO   out 32  architectural HI / LO registers
//   Busy     out 1   registered, high while a mult/div is in flight
//   StallMD  out 1   combinational stall request for the D stage
// The result is computed at issue and held in pending registers; the
// down-counter only models latency and releases the result when it expires.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        DUseMD,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy,
  output logic        StallMD
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);

  state_e             r_state;
  state_e             w_stateNext;
  logic               r_busy;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [31:0]        r_pendHi;
  logic [31:0]        r_pendLo;
  logic               r_pendWr;

  logic [31:0]        w_calcHi;
  logic [31:0]        w_calcLo;
  logic               w_calcDz;
  logic               w_issueMD;
  logic               w_issueHi;
  logic               w_issueLo;
  logic               w_done;
  logic [CNT_W-1:0]   w_cntLoad;

  mdu_calc u_calc (
    .MDop (MDop),
    .A    (A),
    .B    (B),
    .hi   (w_calcHi),
    .lo   (w_calcLo),
    .dz   (w_calcDz)
  );

  // State register. Busy is registered alongside the state so it rises
  // the cycle after issue and falls the cycle after the count expires.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_busy  <= (w_stateNext == ST_RUN);
    end
  end

  // Next-state logic: leave IDLE on a long-latency issue, return when the
  // counter is about to reach zero.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: if (w_issueMD) w_stateNext = ST_RUN;
      ST_RUN:  if (w_done)    w_stateNext = ST_IDLE;
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Control decode. Every Start is ignored outside IDLE, including the
  // single-cycle moves, so an in-flight result cannot be overwritten.
  always_comb begin
    w_issueMD = 1'b0;
    w_issueHi = 1'b0;
    w_issueLo = 1'b0;
    w_done    = 1'b0;
    w_cntLoad = CNT_W'(MULT_CYCLES);
    if (r_state == ST_IDLE && Start) begin
      w_issueMD = isMulDiv(MDop);
      w_issueHi = (MDop == MD_MTHI);
      w_issueLo = (MDop == MD_MTLO);
    end
    if (r_state == ST_RUN && r_cnt == CNT_W'(1)) begin
      w_done = 1'b1;
    end
    if (isDiv(MDop)) begin
      w_cntLoad = CNT_W'(DIV_CYCLES);
    end
  end

  // Datapath registers: latency counter, pending result, and HI/LO.
  // A divide by zero clears r_pendWr so completion leaves HI/LO untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_pendHi <= 32'd0;
      r_pendLo <= 32'd0;
      r_pendWr <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      if (w_issueMD) begin
        r_pendHi <= w_calcHi;
        r_pendLo <= w_calcLo;
        r_pendWr <= ~w_calcDz;
        r_cnt    <= w_cntLoad;
      end else if (r_state == ST_RUN) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_done && r_pendWr) begin
        r_hi <= r_pendHi;
        r_lo <= r_pendLo;
      end
      if (w_issueHi) r_hi <= A;
      if (w_issueLo) r_lo <= A;
    end
  end

  assign HI      = r_hi;
  assign LO      = r_lo;
  assign Busy    = r_busy;
  assign StallMD = DUseMD & (r_busy | (Start & isMulDiv(MDop)));

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl -- directed self-checking bench for mdu_ctrl.
// Inputs change 1ns after a rising edge; outputs are sampled there too,
// so each "cycle" below starts just after an edge.
module tb_mdu_ctrl;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  MDop = 3'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        DUseMD = 1'b0;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        Busy;
  logic        StallMD;

  int testsRun = 0;
  int testsFailed = 0;
  logic [31:0] expHi = 32'd0;
  logic [31:0] expLo = 32'd0;

  mdu_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .Start   (Start),
    .MDop    (MDop),
    .A       (A),
    .B       (B),
    .DUseMD  (DUseMD),
    .HI      (HI),
    .LO      (LO),
    .Busy    (Busy),
    .StallMD (StallMD)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one Start for a single cycle, then release it.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1;
    MDop  = op;
    A     = a;
    B     = b;
    step();
    Start = 1'b0;
    MDop  = OP_NONE;
  endtask

  // Reset state, then reset winning over a Start on the same edge.
  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    testsRun++; if (HI !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset_hi got %h want %h", HI, 32'd0); end
    testsRun++; if (LO !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset_lo got %h want %h", LO, 32'd0); end
    testsRun++; if (Busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy got %b want 0", Busy); end
    testsRun++; if (StallMD !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_stall got %b want 0", StallMD); end
    Start = 1'b1; MDop = OP_MULT; A = 32'd3; B = 32'd5;
    step();
    Start = 1'b0; MDop = OP_NONE; reset = 1'b0;
    testsRun++; if (Busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_prio_busy got %b want 0", Busy); end
    repeat (6) step();
    testsRun++; if (LO !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset_prio_lo got %h want %h", LO, 32'd0); end
  endtask

  // mthi/mtlo land on the next edge without Busy; opcodes 0 and 7 do nothing.
  task automatic test_moves();
    issue(OP_MTHI, 32'h11, 32'h0);
    expHi = 32'h11;
    testsRun++; if (HI !== expHi) begin testsFailed++; $display("[TB] FAIL mthi got %h want %h", HI, expHi); end
    testsRun++; if (Busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL mthi_busy got %b want 0", Busy); end
    issue(OP_MTLO, 32'h22, 32'h0);
    expLo = 32'h22;
    testsRun++; if (LO !== expLo) begin testsFailed++; $display("[TB] FAIL mtlo got %h want %h", LO, expLo); end
    issue(OP_RSVD, 32'h99, 32'h99);
    issue(OP_NONE, 32'h77, 32'h77);
    testsRun++; if (Busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL nop_busy got %b want 0", Busy); end
    testsRun++; if (HI !== expHi || LO !== expLo) begin testsFailed++; $display("[TB] FAIL nop_hilo got %h/%h want %h/%h", HI, LO, expHi, expLo); end
  endtask

  // Signed and unsigned multiplies: five busy cycles, old HI/LO held meanwhile.
  task automatic test_mult();
    logic [2:0]  ops [2] = '{OP_MULT, OP_MULTU};
    logic [31:0] as  [2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs  [2] = '{32'd2, 32'hFFFF_FFFF};
    logic [31:0] his [2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE};
    logic [31:0] los [2] = '{32'hFFFF_FFFE, 32'h0000_0001};
    for (int v = 0; v < 2; v++) begin
      issue(ops[v], as[v], bs[v]);
      for (int k = 1; k <= 5; k++) begin
        testsRun++; if (Busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL mult%0d_busy c%0d got %b want 1", v, k, Busy); end
        testsRun++; if (HI !== expHi || LO !== expLo) begin testsFailed++; $display("[TB] FAIL mult%0d_hold c%0d got %h/%h want %h/%h", v, k, HI, LO, expHi, expLo); end
        step();
      end
      expHi = his[v];
      expLo = los[v];
      testsRun++; if (Busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL mult%0d_done_busy got %b want 0", v, Busy); end
      testsRun++; if (HI !== expHi) begin testsFailed++; $display("[TB] FAIL mult%0d_hi got %h want %h", v, HI, expHi); end
      testsRun++; if (LO !== expLo) begin testsFailed++; $display("[TB] FAIL mult%0d_lo got %h want %h", v, LO, expLo); end
    end
  endtask

  // divu 100/7, signed -7/2, and the 0x80000000 / -1 overflow case.
  task automatic test_div();
    logic [2:0]  ops [3] = '{OP_DIVU, OP_DIV, OP_DIV};
    logic [31:0] as  [3] = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000};
    logic [31:0] bs  [3] = '{32'd7, 32'd2, 32'hFFFF_FFFF};
    logic [31:0] his [3] = '{32'd2, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] los [3] = '{32'd14, 32'hFFFF_FFFD, 32'h8000_0000};
    for (int v = 0; v < 3; v++) begin
      issue(ops[v], as[v], bs[v]);
      for (int k = 1; k <= 10; k++) begin
        testsRun++; if (Busy !== 1'b1 || HI !== expHi) begin testsFailed++; $display("[TB] FAIL div%0d_run c%0d busy %b hi %h want 1 %h", v, k, Busy, HI, expHi); end
        step();
      end
      expHi = his[v];
      expLo = los[v];
      testsRun++; if (Busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL div%0d_done_busy got %b want 0", v, Busy); end
      testsRun++; if (HI !== expHi) begin testsFailed++; $display("[TB] FAIL div%0d_hi got %h want %h", v, HI, expHi); end
      testsRun++; if (LO !== expLo) begin testsFailed++; $display("[TB] FAIL div%0d_lo got %h want %h", v, LO, expLo); end
    end
  endtask

  // Divide by zero still costs ten cycles and leaves HI/LO alone.
  task automatic test_div_zero();
    issue(OP_MTHI, 32'h11, 32'h0);
    issue(OP_MTLO, 32'h22, 32'h0);
    expHi = 32'h11;
    expLo = 32'h22;
    issue(OP_DIVU, 32'd5, 32'd0);
    for (int k = 1; k <= 10; k++) begin
      testsRun++; if (Busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL dz_busy c%0d got %b want 1", k, Busy); end
      step();
    end
    testsRun++; if (Busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL dz_done_busy got %b want 0", Busy); end
    testsRun++; if (HI !== 32'h11) begin testsFailed++; $display("[TB] FAIL dz_hi got %h want %h", HI, 32'h11); end
    testsRun++; if (LO !== 32'h22) begin testsFailed++; $display("[TB] FAIL dz_lo got %h want %h", LO, 32'h22); end
  endtask

  // StallMD across a multu issued with DUseMD, then a non-stalling mthi.
  task automatic test_hazard();
    DUseMD = 1'b1;
    Start = 1'b1; MDop = OP_MULTU; A = 32'd3; B = 32'd4;
    #1;
    testsRun++; if (StallMD !== 1'b1) begin testsFailed++; $display("[TB] FAIL stall_issue got %b want 1", StallMD); end
    step();
    Start = 1'b0; MDop = OP_NONE;
    for (int k = 1; k <= 5; k++) begin
      #1;
      testsRun++; if (StallMD !== 1'b1) begin testsFailed++; $display("[TB] FAIL stall_run c%0d got %b want 1", k, StallMD); end
      step();
    end
    #1;
    testsRun++; if (StallMD !== 1'b0) begin testsFailed++; $display("[TB] FAIL stall_release got %b want 0", StallMD); end
    expHi = 32'd0;
    expLo = 32'd12;
    testsRun++; if (HI !== expHi || LO !== expLo) begin testsFailed++; $display("[TB] FAIL multu_small got %h/%h want %h/%h", HI, LO, expHi, expLo); end
    Start = 1'b1; MDop = OP_MTHI; A = 32'hABCD;
    #1;
    testsRun++; if (StallMD !== 1'b0) begin testsFailed++; $display("[TB] FAIL stall_mthi got %b want 0", StallMD); end
    step();
    Start = 1'b0; MDop = OP_NONE;
    expHi = 32'hABCD;
    testsRun++; if (HI !== expHi) begin testsFailed++; $display("[TB] FAIL mthi_hazard got %h want %h", HI, expHi); end
    DUseMD = 1'b0;
  endtask

  // Reset during cycle t+3 of a divide discards it entirely.
  task automatic test_reset_mid();
    issue(OP_DIVU, 32'd100, 32'd7);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    expHi = 32'd0;
    expLo = 32'd0;
    testsRun++; if (Busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL rmid_busy got %b want 0", Busy); end
    testsRun++; if (HI !== 32'd0 || LO !== 32'd0) begin testsFailed++; $display("[TB] FAIL rmid_hilo got %h/%h want 0/0", HI, LO); end
    repeat (12) step();
    testsRun++; if (HI !== 32'd0 || LO !== 32'd0 || Busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL rmid_late got %h/%h busy %b want 0/0 busy 0", HI, LO, Busy); end
  endtask

  // Starts during RUN (mult, then mthi) are dropped; the divide lands on time.
  task automatic test_back_to_back();
    issue(OP_MTHI, 32'h55, 32'h0);
    issue(OP_MTLO, 32'h66, 32'h0);
    expHi = 32'h55;
    expLo = 32'h66;
    issue(OP_DIVU, 32'd100, 32'd7);
    step();
    issue(OP_MULT, 32'd3, 32'd5);
    issue(OP_MTHI, 32'hDEAD, 32'h0);
    for (int k = 4; k <= 10; k++) begin
      testsRun++; if (Busy !== 1'b1 || HI !== expHi || LO !== expLo) begin testsFailed++; $display("[TB] FAIL b2b_run c%0d busy %b got %h/%h want 1 %h/%h", k, Busy, HI, LO, expHi, expLo); end
      step();
    end
    expHi = 32'd2;
    expLo = 32'd14;
    testsRun++; if (Busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_done_busy got %b want 0", Busy); end
    testsRun++; if (HI !== expHi || LO !== expLo) begin testsFailed++; $display("[TB] FAIL b2b_result got %h/%h want %h/%h", HI, LO, expHi, expLo); end
    repeat (8) step();
    testsRun++; if (HI !== expHi || LO !== expLo || Busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_after got %h/%h busy %b want %h/%h busy 0", HI, LO, Busy, expHi, expLo); end
  endtask

  // Safety net so a broken design can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired after %0d checks", testsRun);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_moves();
    test_mult();
    test_div();
    test_div_zero();
    test_hazard();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
